dds_phase_gen: RTL and testbench

//  Parametrised multi-channel DDS phase/address generator feeding the sine ROM(s).
//  One shared phase accumulator with a chirp (theta) accumulator for up/triangle LFM.
//  Per-channel static phase offsets give I/Q or multi-phase outputs.

---
 rtl/dds_phase_gen_pkg.sv | 22 ++
 rtl/dds_phase_gen_if.sv | 28 ++
 rtl/dds_phase_gen_chirp_acc.sv | 48 ++++
 rtl/dds_phase_gen.sv | 137 +++++++++++++
 tb/tb_dds_phase_gen.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dds_phase_gen_pkg.sv
// Shared constants for the DDS phase generator: mode codes, FSM encodings and
// the quarter-wave offset helper used to derive COS from the sine ROM.
package dds_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_SIN     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_COS     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_LFM_UP  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_LFM_TRI = 3'd3;
  localparam logic [MODE_W-1:0] MODE_PSK     = 3'd4;
  localparam logic [MODE_W-1:0] MODE_NLFM    = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // 90 degrees expressed in ROM address units
  function automatic logic [31:0] quarter_wave(input int unsigned addr_w);
    return 32'(1) << (addr_w - 2);
  endfunction

endpackage

// File: rtl/dds_phase_gen_if.sv
// Configuration channel of the DDS phase generator (valid/ready handshake).
interface dds_phase_gen_if #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned NCH    = 2,
  parameter int unsigned LEN_W  = 16
);
  import dds_pkg::*;

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [MODE_W-1:0]       cfg_mode;
  logic [ACC_W-1:0]        cfg_fw;
  logic [ACC_W-1:0]        cfg_chirp;
  logic [LEN_W-1:0]        cfg_sweep_len;
  logic [NCH*ADDR_W-1:0]   cfg_poff;

  modport master (
    output cfg_valid, cfg_mode, cfg_fw, cfg_chirp, cfg_sweep_len, cfg_poff,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_fw, cfg_chirp, cfg_sweep_len, cfg_poff,
    output cfg_ready
  );

endinterface

// File: rtl/dds_phase_gen_chirp_acc.sv
// Phase accumulator plus chirp (theta) accumulator; wrap restarts the phase,
// and in triangle mode flips the sweep direction while keeping theta.
module dds_chirp_acc #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              wrap,
  input  logic              up,
  input  logic              tri_mode,
  input  logic [ACC_W-1:0]  fw,
  input  logic [ACC_W-1:0]  chirp,
  output logic [ADDR_W-1:0] phase
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] theta;
  logic             dir;

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      acc   <= '0;
      theta <= '0;
      dir   <= 1'b0;
    end else if (wrap) begin
      acc <= '0;
      if (tri_mode) begin
        dir <= ~dir;
      end else begin
        theta <= '0;
        dir   <= 1'b0;
      end
    end else begin
      acc <= acc + fw + theta;
      if (up)
        theta <= theta + chirp;
      else if (tri_mode)
        theta <= dir ? theta - chirp : theta + chirp;
      else
        theta <= '0;
    end
  end

  assign phase = acc[ACC_W-1 -: ADDR_W];

endmodule

// File: rtl/dds_phase_gen.sv
// Multi-channel DDS phase/address generator: gated sweep FSM, double-buffered
// config that swaps only at sweep boundaries, per-channel offset adders.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned NCH    = 2,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  dds_phase_gen_if.slave        cfg,
  input  logic [ADDR_W-1:0]     mod_phase,
  input  logic                  gate,
  output logic [NCH*ADDR_W-1:0] rom_addr,
  output logic                  addr_valid,
  output logic                  sweep_start
);

  localparam int unsigned CFG_W = MODE_W + 2 * ACC_W + LEN_W + NCH * ADDR_W;
  localparam logic [ADDR_W-1:0] COS_BASE = ADDR_W'(quarter_wave(ADDR_W));

  logic [0:0]            state, state_nxt;
  logic [CFG_W-1:0]      act_cfg, sh_cfg, cfg_in_c;
  logic                  loaded, pending;
  logic [LEN_W-1:0]      cnt, last_c;
  logic                  run_c, wrap_c, hs_c;
  logic [MODE_W-1:0]     act_mode;
  logic [ACC_W-1:0]      act_fw, act_chirp;
  logic [LEN_W-1:0]      act_len;
  logic [NCH*ADDR_W-1:0] act_poff;
  logic [ADDR_W-1:0]     phase, base_c;

  assign cfg_in_c = {cfg.cfg_mode, cfg.cfg_fw, cfg.cfg_chirp, cfg.cfg_sweep_len, cfg.cfg_poff};
  assign {act_mode, act_fw, act_chirp, act_len, act_poff} = act_cfg;

  assign cfg.cfg_ready = !pending;
  assign hs_c          = cfg.cfg_valid && !pending;
  assign last_c        = (act_len == '0) ? '0 : act_len - LEN_W'(1);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Gate dropping takes priority over a coincident sweep boundary
  always_comb begin
    state_nxt = state;
    run_c     = 1'b0;
    wrap_c    = 1'b0;
    case (state)
      ST_IDLE: if (gate && loaded) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!gate) begin
          state_nxt = ST_IDLE;
        end else begin
          run_c  = 1'b1;
          wrap_c = (cnt == last_c);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Idle (or leaving run) writes active directly; running buffers in shadow
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      act_cfg <= '0;
      sh_cfg  <= '0;
      loaded  <= 1'b0;
      pending <= 1'b0;
    end else if (state == ST_IDLE || !gate) begin
      if (hs_c) begin
        act_cfg <= cfg_in_c;
        loaded  <= 1'b1;
      end else if (pending) begin
        act_cfg <= sh_cfg;
      end
      pending <= 1'b0;
    end else begin
      if (wrap_c && pending) begin
        act_cfg <= sh_cfg;
        pending <= 1'b0;
      end
      if (hs_c) begin
        sh_cfg  <= cfg_in_c;
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || !run_c || wrap_c) cnt <= '0;
    else                                cnt <= cnt + LEN_W'(1);
  end

  dds_chirp_acc #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_acc (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .run      (run_c),
    .wrap     (wrap_c),
    .up       (act_mode == MODE_LFM_UP),
    .tri_mode (act_mode == MODE_LFM_TRI),
    .fw       (act_fw),
    .chirp    (act_chirp),
    .phase    (phase)
  );

  always_comb begin
    base_c = '0;
    case (act_mode)
      MODE_COS:             base_c = COS_BASE;
      MODE_PSK, MODE_NLFM:  base_c = mod_phase;
      default:              base_c = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rom_addr    <= '0;
      addr_valid  <= 1'b0;
      sweep_start <= 1'b0;
    end else begin
      addr_valid  <= (state == ST_RUN);
      sweep_start <= (state == ST_RUN) && (cnt == '0);
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        rom_addr[ch*ADDR_W +: ADDR_W] <= (state == ST_RUN)
          ? phase + base_c + act_poff[ch*ADDR_W +: ADDR_W] : '0;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: hand-computed addresses for each mode,
// mid-sweep config buffering, gate blanking and reset behaviour.
module tb_dds_phase_gen;
  import dds_pkg::*;

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned NCH    = 2;
  localparam int unsigned LEN_W  = 16;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst_n = 1'b0;
  logic [ADDR_W-1:0]     mod_phase = '0;
  logic                  gate = 1'b0;
  logic [NCH*ADDR_W-1:0] rom_addr;
  logic                  addr_valid;
  logic                  sweep_start;

  int total = 0;
  int bad   = 0;

  dds_phase_gen_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .NCH(NCH), .LEN_W(LEN_W)) cfg_bus ();

  dds_phase_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .NCH(NCH), .LEN_W(LEN_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cfg         (cfg_bus),
    .mod_phase   (mod_phase),
    .gate        (gate),
    .rom_addr    (rom_addr),
    .addr_valid  (addr_valid),
    .sweep_start (sweep_start)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ch1 carries a fixed 0x200000 offset over ch0 whenever valid
  task automatic chk_out(input string tag, input logic v, input logic s, input logic [22:0] a0);
    logic [22:0] a1;
    a1 = v ? a0 + 23'h200000 : 23'h0;
    chk({tag, ".valid"}, 64'(addr_valid), 64'(v));
    chk({tag, ".start"}, 64'(sweep_start), 64'(s));
    chk({tag, ".ch0"}, 64'(rom_addr[22:0]), 64'(a0));
    chk({tag, ".ch1"}, 64'(rom_addr[45:23]), 64'(a1));
  endtask

  task automatic set_cfg(input logic [2:0] m, input logic [31:0] fw,
                         input logic [31:0] chirp, input logic [15:0] len);
    cfg_bus.cfg_mode      = m;
    cfg_bus.cfg_fw        = fw;
    cfg_bus.cfg_chirp     = chirp;
    cfg_bus.cfg_sweep_len = len;
  endtask

  // Return to idle, load a config, re-open the gate; ends on the first sweep output
  task automatic restart(input logic [2:0] m, input logic [31:0] fw,
                         input logic [31:0] chirp, input logic [15:0] len);
    gate = 1'b0;
    tick();
    tick();
    set_cfg(m, fw, chirp, len);
    cfg_bus.cfg_valid = 1'b1;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    gate = 1'b1;
    tick();
    tick();
  endtask

  logic [22:0] up_exp  [4]  = '{23'd0, 23'd0, 23'd1, 23'd3};
  logic [22:0] tri_exp [12] = '{23'd0, 23'd0, 23'd1, 23'd3,
                                23'd0, 23'd3, 23'd5, 23'd6,
                                23'd0, 23'd0, 23'd1, 23'd3};

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_poff  = {23'h200000, 23'h0};
    set_cfg(MODE_SIN, 32'h0, 32'h0, 16'd0);

    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 23'h0);
    chk("reset.ready", 64'(cfg_bus.cfg_ready), 64'(1));
    sys_rst_n = 1'b1;

    restart(MODE_SIN, 32'h200, 32'h0, 16'd8);
    for (int k = 0; k < 10; k++) begin
      chk_out($sformatf("sin.k%0d", k), 1'b1, (k % 8) == 0, 23'(k % 8));
      tick();
    end

    restart(MODE_COS, 32'h200, 32'h0, 16'd8);
    chk_out("cos.k0", 1'b1, 1'b1, 23'h200000);
    tick();
    chk_out("cos.k1", 1'b1, 1'b0, 23'h200001);

    restart(MODE_LFM_UP, 32'h0, 32'h200, 16'd4);
    for (int k = 0; k < 8; k++) begin
      chk_out($sformatf("up.k%0d", k), 1'b1, (k % 4) == 0, up_exp[k % 4]);
      tick();
    end

    restart(MODE_LFM_TRI, 32'h0, 32'h200, 16'd4);
    for (int k = 0; k < 12; k++) begin
      chk_out($sformatf("tri.k%0d", k), 1'b1, (k % 4) == 0, tri_exp[k]);
      tick();
    end

    mod_phase = 23'h100;
    restart(MODE_PSK, 32'h200, 32'h0, 16'd8);
    chk_out("psk.k0", 1'b1, 1'b1, 23'h100);
    mod_phase = 23'h7FFFFF;
    tick();
    chk_out("psk.wrap", 1'b1, 1'b0, 23'h0);
    mod_phase = 23'h0;

    restart(MODE_SIN, 32'h200, 32'h0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("len0.k%0d", k), 1'b1, 1'b1, 23'h0);
      tick();
    end

    // Mid-sweep reconfiguration waits for the boundary
    restart(MODE_SIN, 32'h200, 32'h0, 16'd8);
    chk("mid.ready0", 64'(cfg_bus.cfg_ready), 64'(1));
    set_cfg(MODE_SIN, 32'h400, 32'h0, 16'd8);
    cfg_bus.cfg_valid = 1'b1;
    tick();
    chk_out("mid.k1", 1'b1, 1'b0, 23'd1);
    chk("mid.ready1", 64'(cfg_bus.cfg_ready), 64'(0));
    set_cfg(MODE_SIN, 32'h800, 32'h0, 16'd8);
    tick();
    chk("mid.stall2", 64'(cfg_bus.cfg_ready), 64'(0));
    tick();
    chk_out("mid.k3", 1'b1, 1'b0, 23'd3);
    chk("mid.stall3", 64'(cfg_bus.cfg_ready), 64'(0));
    cfg_bus.cfg_valid = 1'b0;
    tick();
    tick();
    tick();
    chk_out("mid.k6", 1'b1, 1'b0, 23'd6);
    chk("mid.ready6", 64'(cfg_bus.cfg_ready), 64'(0));
    tick();
    chk_out("mid.k7", 1'b1, 1'b0, 23'd7);
    chk("mid.ready7", 64'(cfg_bus.cfg_ready), 64'(1));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("mid.new%0d", k), 1'b1, k == 0, 23'(2 * k));
    end

    // Gate blanking mid-sweep
    gate = 1'b0;
    tick();
    chk_out("gate.last", 1'b1, 1'b0, 23'd8);
    tick();
    chk_out("gate.blank", 1'b0, 1'b0, 23'h0);
    gate = 1'b1;
    tick();
    chk_out("gate.reenter", 1'b0, 1'b0, 23'h0);
    tick();
    chk_out("gate.k0", 1'b1, 1'b1, 23'h0);
    tick();
    chk_out("gate.k1", 1'b1, 1'b0, 23'd2);

    // Reset while running drops the loaded config
    sys_rst_n = 1'b0;
    tick();
    chk_out("rst.run", 1'b0, 1'b0, 23'h0);
    chk("rst.ready", 64'(cfg_bus.cfg_ready), 64'(1));
    sys_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst.noload%0d", k), 64'(addr_valid), 64'(0));
    end
    set_cfg(MODE_SIN, 32'h200, 32'h0, 16'd8);
    cfg_bus.cfg_valid = 1'b1;
    tick();
    chk("rst.hs", 64'(addr_valid), 64'(0));
    cfg_bus.cfg_valid = 1'b0;
    tick();
    chk("rst.enter", 64'(addr_valid), 64'(0));
    tick();
    chk_out("rst.k0", 1'b1, 1'b1, 23'h0);
    tick();
    chk_out("rst.k1", 1'b1, 1'b0, 23'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
